// File: rtl/divisor_restas_ctrl.sv
// Sequential 4-bit unsigned divider by repeated subtraction around one Restador4_Bits.
// Optional macro DIVISION_CERO_EN: a zero divisor skips the subtraction loop and raises div_cero.

module Restador4_Bits (
    input  logic [3:0] X,
    input  logic [3:0] Y,
    output logic [3:0] R,
    output logic       CarriNegSalida
);

    logic [4:0] diferencia;

    // The fifth bit of the widened difference is the borrow out.
    assign diferencia     = {1'b0, X} - {1'b0, Y};
    assign R              = diferencia[3:0];
    assign CarriNegSalida = diferencia[4];

endmodule

module divisor_restas_ctrl #(
    parameter bit PULSO_LISTO = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inicio,
    input  logic [3:0] dividendo,
    input  logic [3:0] divisor,
    output logic       ocupado,
    output logic       listo,
    output logic [3:0] cociente,
    output logic [3:0] residuo,
    output logic       div_cero
);

    typedef enum logic [1:0] {
        REPOSO = 2'd0,
        RESTA  = 2'd1,
        FIN    = 2'd2
    } estado_t;

    estado_t    estado;
    estado_t    estado_sig;
    logic [3:0] reg_a;
    logic [3:0] reg_b;
    logic [3:0] reg_q;
    logic [3:0] resta_r;
    logic       resta_borrow;
    logic       aceptar;
    logic       seguir;
    logic       terminar;
    logic       cero_directo;

    Restador4_Bits u_restador (
        .X              (reg_a),
        .Y              (reg_b),
        .R              (resta_r),
        .CarriNegSalida (resta_borrow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= REPOSO;
        end else begin
            estado <= estado_sig;
        end
    end

    always_comb begin
        estado_sig = estado;
        case (estado)
            REPOSO: begin
                if (inicio) begin
                    estado_sig = cero_directo ? FIN : RESTA;
                end
            end
            RESTA: begin
                if (!seguir) begin
                    estado_sig = FIN;
                end
            end
            FIN:     estado_sig = REPOSO;
            default: estado_sig = REPOSO;
        endcase
    end

    always_comb begin
        ocupado  = (estado != REPOSO);
        aceptar  = (estado == REPOSO) && inicio;
        seguir   = (estado == RESTA) && !resta_borrow && (reg_q != 4'hF);
        terminar = (estado == RESTA) && !seguir;
`ifdef DIVISION_CERO_EN
        cero_directo = aceptar && (divisor == 4'd0);
`else
        cero_directo = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_a <= 4'd0;
            reg_b <= 4'd0;
            reg_q <= 4'd0;
        end else if (aceptar) begin
            reg_a <= dividendo;
            reg_b <= divisor;
            reg_q <= 4'd0;
        end else if (seguir) begin
            reg_a <= resta_r;
            reg_q <= reg_q + 4'd1;
        end
    end

    // Results hold across a new start; they only change on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cociente <= 4'd0;
            residuo  <= 4'd0;
        end else if (terminar) begin
            cociente <= reg_q;
            residuo  <= reg_a;
        end else if (cero_directo) begin
            cociente <= 4'hF;
            residuo  <= dividendo;
        end
    end

    // Setting listo takes priority so a zero-divisor start can clear and set in one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            listo <= 1'b0;
        end else if (terminar || cero_directo) begin
            listo <= 1'b1;
        end else if (aceptar && !PULSO_LISTO) begin
            listo <= 1'b0;
        end else if ((estado == FIN) && PULSO_LISTO) begin
            listo <= 1'b0;
        end
    end

`ifdef DIVISION_CERO_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cero <= 1'b0;
        end else if (aceptar) begin
            div_cero <= (divisor == 4'd0);
        end
    end
`else
    assign div_cero = 1'b0;
`endif

endmodule

// File: tb/tb_divisor_restas_ctrl.sv
// Randomized self-checking bench for divisor_restas_ctrl; runs a pulse-mode and a level-mode instance side by side.
// Honours DIVISION_CERO_EN when the same macro is defined for the bench build.

module tb_divisor_restas_ctrl;

    logic       clk;
    logic       rst_n;
    logic       inicio;
    logic [3:0] dividendo;
    logic [3:0] divisor;

    logic       ocupado_p, listo_p, div_cero_p;
    logic [3:0] cociente_p, residuo_p;
    logic       ocupado_n, listo_n, div_cero_n;
    logic [3:0] cociente_n, residuo_n;

    int vectors;
    int miscompares;

    logic [3:0] prev_q;
    logic [3:0] prev_r;
    logic       prev_dz;

    divisor_restas_ctrl #(.PULSO_LISTO(1'b1)) dut_pulso (
        .clk       (clk),
        .rst_n     (rst_n),
        .inicio    (inicio),
        .dividendo (dividendo),
        .divisor   (divisor),
        .ocupado   (ocupado_p),
        .listo     (listo_p),
        .cociente  (cociente_p),
        .residuo   (residuo_p),
        .div_cero  (div_cero_p)
    );

    divisor_restas_ctrl #(.PULSO_LISTO(1'b0)) dut_nivel (
        .clk       (clk),
        .rst_n     (rst_n),
        .inicio    (inicio),
        .dividendo (dividendo),
        .divisor   (divisor),
        .ocupado   (ocupado_n),
        .listo     (listo_n),
        .cociente  (cociente_n),
        .residuo   (residuo_n),
        .div_cero  (div_cero_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ocupado_p"}, {7'd0, ocupado_p}, 8'd0);
        checkOutput({tag, "_listo_p"}, {7'd0, listo_p}, 8'd0);
        checkOutput({tag, "_cociente_p"}, {4'd0, cociente_p}, 8'd0);
        checkOutput({tag, "_residuo_p"}, {4'd0, residuo_p}, 8'd0);
        checkOutput({tag, "_div_cero_p"}, {7'd0, div_cero_p}, 8'd0);
        checkOutput({tag, "_ocupado_n"}, {7'd0, ocupado_n}, 8'd0);
        checkOutput({tag, "_listo_n"}, {7'd0, listo_n}, 8'd0);
        checkOutput({tag, "_cociente_n"}, {4'd0, cociente_n}, 8'd0);
        checkOutput({tag, "_residuo_n"}, {4'd0, residuo_n}, 8'd0);
        checkOutput({tag, "_div_cero_n"}, {7'd0, div_cero_n}, 8'd0);
    endtask

    // Starts one division at the next edge and checks both instances every cycle until idle again.
    task automatic applyStimulus(input logic [3:0] dd, input logic [3:0] dv, input bit agitar);
        logic [3:0] exp_q, exp_r;
        logic       exp_dz;
        int         le;
        bit         zero_macro;

        zero_macro = 1'b0;
`ifdef DIVISION_CERO_EN
        zero_macro = 1'b1;
`endif
        if (dv == 4'd0) begin
            exp_q = 4'hF;
            exp_r = dd;
            le    = zero_macro ? 0 : 16;
        end else begin
            exp_q = dd / dv;
            exp_r = dd % dv;
            le    = int'(exp_q) + 1;
        end
        exp_dz = zero_macro && (dv == 4'd0);

        dividendo = dd;
        divisor   = dv;
        inicio    = 1'b1;

        for (int k = 0; k <= le + 2; k++) begin
            logic [3:0] eq, er;
            @(posedge clk);
            #1;
            eq = (k >= le) ? exp_q : prev_q;
            er = (k >= le) ? exp_r : prev_r;
            checkOutput("ocupado_p", {7'd0, ocupado_p}, {7'd0, (k <= le)});
            checkOutput("ocupado_n", {7'd0, ocupado_n}, {7'd0, (k <= le)});
            checkOutput("listo_p", {7'd0, listo_p}, {7'd0, (k == le)});
            checkOutput("listo_n", {7'd0, listo_n}, {7'd0, (k >= le)});
            checkOutput("cociente_p", {4'd0, cociente_p}, {4'd0, eq});
            checkOutput("residuo_p", {4'd0, residuo_p}, {4'd0, er});
            checkOutput("cociente_n", {4'd0, cociente_n}, {4'd0, eq});
            checkOutput("residuo_n", {4'd0, residuo_n}, {4'd0, er});
            checkOutput("div_cero_p", {7'd0, div_cero_p}, {7'd0, exp_dz});
            checkOutput("div_cero_n", {7'd0, div_cero_n}, {7'd0, exp_dz});
            if (agitar && (k + 1 <= le + 1)) begin
                inicio    = 1'($urandom);
                dividendo = 4'($urandom);
                divisor   = 4'($urandom);
            end else begin
                inicio = 1'b0;
            end
        end
        prev_q  = exp_q;
        prev_r  = exp_r;
        prev_dz = exp_dz;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        prev_q      = 4'd0;
        prev_r      = 4'd0;
        prev_dz     = 1'b0;
        rst_n       = 1'b0;
        inicio      = 1'b0;
        dividendo   = 4'd0;
        divisor     = 4'd0;

        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkAllZero("post_reset");

        applyStimulus(4'd7, 4'd2, 1'b0);
        applyStimulus(4'd3, 4'd5, 1'b0);
        applyStimulus(4'd15, 4'd1, 1'b1);
        applyStimulus(4'd9, 4'd0, 1'b0);

        // Abandon 13/2 after edge 3 with an asynchronous reset.
        dividendo = 4'd13;
        divisor   = 4'd2;
        inicio    = 1'b1;
        for (int k = 0; k <= 3; k++) begin
            @(posedge clk);
            #1;
            inicio = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        checkAllZero("mid_reset");
        @(posedge clk);
        #1;
        checkAllZero("mid_reset_hold");
        rst_n   = 1'b1;
        prev_q  = 4'd0;
        prev_r  = 4'd0;
        prev_dz = 1'b0;
        applyStimulus(4'd6, 4'd3, 1'b0);

        applyStimulus(4'd8, 4'd3, 1'b0);
        applyStimulus(4'd12, 4'd4, 1'b0);

        for (int i = 0; i < 30; i++) begin
            applyStimulus(4'($urandom), 4'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
